// File: rtl/wb_pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block: FSM states,
// register addresses and STATUS bit positions.
package wb_pwm_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [1:0] ADR_HIGH   = 2'd0;
    localparam logic [1:0] ADR_PERIOD = 2'd1;
    localparam logic [1:0] ADR_STATUS = 2'd2;

    localparam int ST_VALID = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_LEVEL = 2;
    localparam int ST_IEN   = 3;

endpackage

// File: rtl/wb_pwm_capture_if.sv
// Wishbone B4 pipelined register bus used by the PWM capture block.
interface wb_pwm_capture_if #(
    parameter int BITS = 8
);
    logic            wb_stb_i;
    logic            wb_we_i;
    logic [1:0]      wb_adr_i;
    logic [BITS-1:0] wb_dat_i;
    logic [BITS-1:0] wb_dat_o;
    logic            wb_ack_o;
    logic            wb_stall_o;

    modport slave (
        input  wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );

    modport master (
        output wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface

// File: rtl/wb_pwm_capture_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM input plus a delay flop
// for single-cycle rise/fall pulses.
module pwm_edge_sync (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= pwm_in;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~dly_q;
    assign fall  = ~sync_q & dly_q;
endmodule

// File: rtl/wb_pwm_capture.sv
// PWM input capture: measures high time and period of pwm_in in clock cycles
// and exposes them on a Wishbone slave. Optional irq_o via WB_PWM_CAPTURE_IRQ_EN.
//
// state | meaning
// IDLE  | waiting for a rise; partial periods are ignored
// HIGH  | counting cycles while the synchronized input is 1
// LOW   | counting cycles while the synchronized input is 0
module wb_pwm_capture
    import wb_pwm_capture_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    wb_pwm_capture_if.slave        wb,
    input  logic                   pwm_in
`ifdef WB_PWM_CAPTURE_IRQ_EN
    ,
    output logic                   irq_o
`endif
);
    localparam logic [BITS-1:0] CNT_MAX = '1;

    logic            level, rise, fall;
    state_t          state;
    logic [BITS-1:0] cnt;
    logic [BITS-1:0] high_snap;
    logic [BITS-1:0] high_reg;
    logic [BITS-1:0] period_reg;
    logic [BITS-1:0] period_shadow;
    logic            valid;
    logic            ovf;
    logic            ien;
    logic            st_wr;
    logic [BITS-1:0] status_word;
    logic [BITS-1:0] rd_mux;
    logic            unused_dat;

    pwm_edge_sync u_sync (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .pwm_in   (pwm_in),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    assign st_wr      = wb.wb_stb_i & wb.wb_we_i & (wb.wb_adr_i == ADR_STATUS);
    assign unused_dat = ^wb.wb_dat_i;

    // Software W1C is applied first so that a hardware set later in the block wins.
    // In HIGH the saturation check precedes the fall check: a fall at CNT_MAX
    // would push the period count past the counter width.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            high_snap  <= '0;
            high_reg   <= '0;
            period_reg <= '0;
            valid      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (st_wr && wb.wb_dat_i[ST_VALID]) valid <= 1'b0;
            if (st_wr && wb.wb_dat_i[ST_OVF])   ovf   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt   <= BITS'(1);
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (cnt == CNT_MAX) begin
                        ovf   <= 1'b1;
                        state <= IDLE;
                    end else if (fall) begin
                        high_snap <= cnt;
                        cnt       <= cnt + 1'b1;
                        state     <= LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        high_reg   <= high_snap;
                        period_reg <= cnt;
                        valid      <= 1'b1;
                        cnt        <= BITS'(1);
                        state      <= HIGH;
                    end else if (cnt == CNT_MAX) begin
                        ovf   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        status_word           = '0;
        status_word[ST_VALID] = valid;
        status_word[ST_OVF]   = ovf;
        status_word[ST_LEVEL] = level;
        status_word[ST_IEN]   = ien;
    end

    always_comb begin
        rd_mux = '0;
        case (wb.wb_adr_i)
            ADR_HIGH:   rd_mux = high_reg;
            ADR_PERIOD: rd_mux = period_shadow;
            ADR_STATUS: rd_mux = status_word;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wb.wb_ack_o   <= 1'b0;
            wb.wb_dat_o   <= '0;
            period_shadow <= '0;
        end else begin
            wb.wb_ack_o <= wb.wb_stb_i;
            wb.wb_dat_o <= (wb.wb_stb_i && !wb.wb_we_i) ? rd_mux : '0;
            if (wb.wb_stb_i && !wb.wb_we_i && wb.wb_adr_i == ADR_HIGH)
                period_shadow <= period_reg;
        end
    end

`ifdef WB_PWM_CAPTURE_IRQ_EN
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            ien   <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            if (st_wr) ien <= wb.wb_dat_i[ST_IEN];
            irq_o <= ien & (valid | ovf);
        end
    end
`else
    assign ien = 1'b0;
`endif

    assign wb.wb_stall_o = 1'b0;
endmodule

// File: doc/wb_pwm_capture.md
Name: wb_pwm_capture

Overview:
- Receive-side counterpart of the PWM output channels: measures an external PWM input's high time and period in wb_clk_i cycles.
- Exposes the results as read registers on a Wishbone B4 pipelined slave.
- Used for fan tachometer/servo feedback and for loopback checks of the PWM generator.

Parameters:
- BITS, 8, width of the measurement counters and of wb_dat_i/wb_dat_o; BITS >= 4.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous reset, active-low
- wb_stb_i  in  1  strobe; each strobed cycle is one transfer
- wb_we_i  in  1  1 = write, 0 = read
- wb_adr_i  in  2  register select
- wb_dat_i  in  BITS  write data
- wb_dat_o  out  BITS  read data, valid with wb_ack_o
- wb_ack_o  out  1  acknowledge
- wb_stall_o  out  1  tied 0
- pwm_in  in  1  asynchronous PWM input

Behaviour:
- Reset (wb_rst_i==0 at a clock edge) clears the following:
  - wb_ack_o, wb_dat_o, HIGH, PERIOD and the PERIOD shadow register.
  - The valid and ovf flags and the synchronizer flops.
  - The counter; the FSM returns to IDLE.
  - Reset applies mid-measurement and mid-transfer; any partial period is discarded.
- Input path:
  - 2-FF synchronizer, then one delay flop for edge detect.
  - A rise or fall is detected 2 clocks after pwm_in is sampled.
- FSM states:
  - IDLE: wait for a rise, ignoring any partial period. On rise: cnt<=1, go HIGH.
  - HIGH: cnt++ each clock. On fall: high_snap<=cnt, go LOW.
  - LOW: cnt++ each clock. On rise: HIGH<=high_snap, PERIOD<=cnt, valid<=1, cnt<=1, go HIGH.
- Invariants:
  - HIGH = number of cycles the synchronized input was 1.
  - PERIOD = number of cycles between consecutive synchronized rises.
  - Example: high 3 / low 5 gives HIGH=3, PERIOD=8.
- Saturation:
  - If cnt reaches 2^BITS-1 in HIGH or LOW without an edge: ovf<=1, go IDLE.
  - HIGH, PERIOD and valid are unchanged.
  - A 0% or 100% duty input is therefore reported as ovf plus the level bit.
- Register map:
  - adr 0 HIGH (read-only). A read also copies PERIOD into the PERIOD shadow register.
  - adr 1 PERIOD shadow (read-only). Reading adr 0 then adr 1 yields a coherent pair.
  - adr 2 STATUS: bit0 valid, bit1 ovf, bit2 synchronized level; other bits 0.
    - Writes are write-1-to-clear for bit0 and bit1.
    - A hardware set and a software clear in the same cycle: set wins.
  - adr 3 reads 0; writes are ignored.
  - Writes to adr 0 and adr 1 are ignored.
- Bus timing:
  - wb_ack_o is asserted exactly 1 cycle after each strobed cycle, including back-to-back strobes (one ack per strobe).
  - wb_dat_o is the register value sampled at the strobe edge.
  - wb_dat_o is 0 when no ack is asserted.
  - A capture update in the same cycle as a read: the read returns the pre-update value.

Optional Feature:
- Macro: WB_PWM_CAPTURE_IRQ_EN
- Defined:
  - Adds output irq_o (1 bit, registered).
  - Adds STATUS bit3 ien (read/write, reset 0).
  - irq_o = ien & (valid | ovf); it deasserts the cycle after the flags are cleared.
- Undefined:
  - No irq_o port.
  - STATUS bit3 reads 0; writes to it are ignored.

Decomposition:
- Package wb_pwm_capture_pkg contains:
  - FSM state enum (IDLE, HIGH, LOW).
  - Register address constants (ADR_HIGH=0, ADR_PERIOD=1, ADR_STATUS=2).
  - STATUS bit indices (ST_VALID=0, ST_OVF=1, ST_LEVEL=2, ST_IEN=3).
- One sub-module, pwm_edge_sync:
  - 2-FF synchronizer plus delay flop.
  - Outputs: level, rise, fall.
  - Same clock and reset as the parent.

Test Plan (BITS=8):
- Hold wb_rst_i=0 for 2 cycles, then read adr 0/1/2 -> all return 0; each read is acked 1 cycle after its strobe.
- Repeated waveform, high 3 / low 5 cycles -> after the second rise STATUS=0b001, HIGH=3, PERIOD=8; same values after further periods.
- Read HIGH, switch the waveform to high 6 / low 2 for 3 periods, then read PERIOD -> returns 8. Read HIGH again then PERIOD -> 6 and 8.
- Hold pwm_in=1 for 300 cycles -> STATUS bit1=1, bit2=1, HIGH/PERIOD unchanged. Write STATUS 0x02 -> ovf reads 0.
- Drive wb_rst_i=0 for 1 cycle during HIGH state, then run high 4 / low 4 -> the partial period is not reported; first valid result is HIGH=4, PERIOD=8.
- With WB_PWM_CAPTURE_IRQ_EN: write STATUS 0x08, run one full period -> irq_o=1. Write STATUS 0x09 -> irq_o=0 on the following cycle.
